// File: rtl/batamateur_pkg.sv
// Shared types and constants for the BatAmateur program loader.
// Holds the loader state encoding, the default sync marker and header length.
package batamateur_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA_HI,
      S_DATA_LO,
      S_WRITE,
      S_CKSUM,
      S_RELEASE,
      S_ERROR
   } state_e;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
   localparam int         HDR_LEN      = 4;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and RAM write bus of the program loader.
// master = loader side, slave = host link / CPU top side.
interface program_loader_if;

   logic [7:0]  IN_DATA;
   logic        IN_VALID;
   logic        IN_READY;
   logic [15:0] ADDRESS;
   logic [15:0] DATA;
   logic        DATA_OE;
   logic        RAM_EN;
   logic        RW;

   modport master (
      input  IN_DATA, IN_VALID,
      output IN_READY, ADDRESS, DATA, DATA_OE, RAM_EN, RW
   );

   modport slave (
      output IN_DATA, IN_VALID,
      input  IN_READY, ADDRESS, DATA, DATA_OE, RAM_EN, RW
   );

endinterface

// File: rtl/loader_csum.sv
// 8-bit running byte sum with clear, add-on-accept and compare against din.
module loader_csum (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       add,
   input  logic [7:0] din,
   output logic       match
);

   logic [7:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clr)
         sum_d = '0;
      else if (add)
         sum_d = sum_q + din;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         sum_q <= '0;
      else
         sum_q <= sum_d;

   assign match = (din == sum_q);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: halts the CPU, writes words to RAM, pulses CPU reset.
// Define LOADER_CHECKSUM_EN to expect and check a trailing checksum byte.
module program_loader
   import batamateur_pkg::*;
#(
   parameter int         RST_PULSE = 4,
   parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
   input  logic              CLK,
   input  logic              RST,
   program_loader_if.master  bus,
   output logic              HALT,
   output logic              CPU_RST_N,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR
);

   localparam int PW = $clog2(RST_PULSE + 1);

`ifdef LOADER_CHECKSUM_EN
   localparam state_e S_TAIL = S_CKSUM;
`else
   localparam state_e S_TAIL = S_RELEASE;
`endif

   state_e        state_q, state_d;
   logic [15:0]   addr_q, addr_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   data_q, data_d;
   logic [7:0]    hi_q, hi_d;
   logic [1:0]    idx_q, idx_d;
   logic [PW-1:0] pls_q, pls_d;

   logic       accept;
   logic       is_sync;
   logic [7:0] b;

   assign b       = bus.IN_DATA;
   assign accept  = bus.IN_VALID & bus.IN_READY;
   assign is_sync = (b == SYNC_BYTE);

   assign bus.ADDRESS = addr_q;
   assign bus.DATA    = data_q;

`ifdef LOADER_CHECKSUM_EN
   logic csum_clr, csum_add, csum_match;

   assign csum_clr = accept & is_sync &
                     ((state_q == S_IDLE) | (state_q == S_ERROR));
   assign csum_add = accept & ((state_q == S_HDR) |
                     (state_q == S_DATA_HI) | (state_q == S_DATA_LO));

   loader_csum u_csum (
      .clk   (CLK),
      .rst_n (RST),
      .clr   (csum_clr),
      .add   (csum_add),
      .din   (b),
      .match (csum_match)
   );
`endif

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      data_d       = data_q;
      hi_d         = hi_q;
      idx_d        = idx_q;
      pls_d        = '0;
      bus.IN_READY = 1'b1;
      bus.RAM_EN   = 1'b0;
      bus.RW       = 1'b0;
      bus.DATA_OE  = 1'b0;
      HALT         = 1'b1;
      BUSY         = 1'b1;
      CPU_RST_N    = 1'b1;
      DONE         = 1'b0;
      ERR          = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            HALT = 1'b0;
            BUSY = 1'b0;
            if (accept && is_sync) begin
               state_d = S_HDR;
               idx_d   = '0;
            end
         end
         S_HDR: begin
            if (accept) begin
               idx_d = idx_q + 2'd1;
               unique case (idx_q)
                  2'd0: addr_d[15:8] = b;
                  2'd1: addr_d[7:0]  = b;
                  2'd2: cnt_d[15:8]  = b;
                  2'd3: cnt_d[7:0]   = b;
               endcase
               if (idx_q == 2'(HDR_LEN - 1))
                  state_d = ({cnt_q[15:8], b} == 16'd0) ? S_TAIL : S_DATA_HI;
            end
         end
         S_DATA_HI: begin
            if (accept) begin
               hi_d    = b;
               state_d = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            if (accept) begin
               data_d  = {hi_q, b};
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            bus.IN_READY = 1'b0;
            bus.RAM_EN   = 1'b1;
            bus.RW       = 1'b1;
            bus.DATA_OE  = 1'b1;
            addr_d       = addr_q + 16'd1;
            cnt_d        = cnt_q - 16'd1;
            state_d      = (cnt_q == 16'd1) ? S_TAIL : S_DATA_HI;
         end
         S_CKSUM: begin
`ifdef LOADER_CHECKSUM_EN
            if (accept)
               state_d = csum_match ? S_RELEASE : S_ERROR;
`else
            state_d = S_IDLE;
`endif
         end
         S_RELEASE: begin
            bus.IN_READY = 1'b0;
            if (pls_q < PW'(RST_PULSE)) begin
               CPU_RST_N = 1'b0;
               pls_d     = pls_q + 1'b1;
            end else begin
               DONE    = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_ERROR: begin
`ifdef LOADER_CHECKSUM_EN
            ERR = 1'b1;
`endif
            // Only a fresh SYNC leaves ERROR; it also clears ERR.
            if (accept && is_sync) begin
               state_d = S_HDR;
               idx_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         hi_q    <= '0;
         idx_q   <= '0;
         pls_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         hi_q    <= hi_d;
         idx_q   <= idx_d;
         pls_q   <= pls_d;
      end

endmodule
